// File: rtl/branch_predict_resolve_pkg.sv
// Shared branch opcodes and the direction-resolve helper for the branch unit.
// Operands are sign-extended to BR_MAX_WIDTH before br_cond so one function serves any WIDTH.
package br_pkg;

  localparam int BR_OP_W      = 3;
  localparam int BR_MAX_WIDTH = 64;
  localparam logic [31:0] BR_SEQ_STEP   = 32'd4;
  localparam logic [31:0] BR_DELAY_STEP = 32'd8;

  typedef enum logic [BR_OP_W-1:0] {
    BR_NONE = 3'd0,
    BR_BGEZ = 3'd1,
    BR_BLTZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLEZ = 3'd4,
    BR_BNE  = 3'd5,
    BR_BEQ  = 3'd6
  } br_op_t;

  function automatic logic br_is_branch(input logic [BR_OP_W-1:0] op);
    return (op >= BR_BGEZ) && (op <= BR_BEQ);
  endfunction

  // Opcode 7 is reserved and falls into the default arm as "never taken".
  function automatic logic br_cond(input logic [BR_OP_W-1:0]      op,
                                   input logic [BR_MAX_WIDTH-1:0] rs,
                                   input logic [BR_MAX_WIDTH-1:0] rt);
    logic w_neg;
    logic w_zero;
    logic w_res;
    w_neg  = rs[BR_MAX_WIDTH-1];
    w_zero = (rs == '0);
    w_res  = 1'b0;
    case (op)
      BR_BGEZ: w_res = ~w_neg;
      BR_BLTZ: w_res = w_neg;
      BR_BGTZ: w_res = ~w_neg & ~w_zero;
      BR_BLEZ: w_res = w_neg | w_zero;
      BR_BNE:  w_res = (rs != rt);
      BR_BEQ:  w_res = (rs == rt);
      default: w_res = 1'b0;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_table.sv
// Table of saturating direction counters: one combinational read port, one write port.
// Reads see only pre-edge contents; there is deliberately no write-to-read bypass.
module sat_counter_table #(
  parameter int ENTRIES = 16,
  parameter int BITS    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
  output logic                       o_rd_taken,
  input  logic                       i_wr_en,
  input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
  input  logic                       i_wr_up
);

  localparam logic [BITS-1:0] CTR_INIT = BITS'((1 << (BITS - 1)) - 1);
  localparam logic [BITS-1:0] CTR_MAX  = '1;

  logic [BITS-1:0] r_ctr [ENTRIES];
  logic [BITS-1:0] w_cur;
  logic [BITS-1:0] w_next;

  assign o_rd_taken = r_ctr[i_rd_idx][BITS-1];
  assign w_cur      = r_ctr[i_wr_idx];

  // Step toward the actual direction, clamping at both ends.
  always_comb begin
    w_next = w_cur;
    if (i_wr_up) begin
      if (w_cur != CTR_MAX) w_next = w_cur + BITS'(1);
    end else begin
      if (w_cur != '0) w_next = w_cur - BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch unit: Fetch-time direction prediction, Decode-time signed resolve,
// misprediction redirect, predictor training and branch statistics.
module branch_predict_resolve
  import br_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  input  logic             d_valid,
  input  logic             d_stall,
  input  logic [2:0]       d_branch_op,
  input  logic [31:0]      d_pc,
  input  logic             d_pred_taken,
  input  logic [WIDTH-1:0] d_rs,
  input  logic [WIDTH-1:0] d_rt,
  input  logic [15:0]      d_offset,
  output logic             d_taken,
  output logic             d_redirect,
  output logic [31:0]      d_redirect_pc,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispredict_cnt
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic                    w_is_branch;
  logic                    w_commit;
  logic [BR_MAX_WIDTH-1:0] w_rs_ext;
  logic [BR_MAX_WIDTH-1:0] w_rt_ext;
  logic [31:0]             w_offset_ext;
  logic [31:0]             r_branch_cnt;
  logic [31:0]             r_mispredict_cnt;
  logic                    w_unused;

  assign w_unused = ^{f_pc[31:IDX+2], f_pc[1:0]};

  // Sign-extend so the package compare sees the true two's complement sign at any WIDTH.
  assign w_rs_ext     = BR_MAX_WIDTH'($signed(d_rs));
  assign w_rt_ext     = BR_MAX_WIDTH'($signed(d_rt));
  assign w_offset_ext = {{14{d_offset[15]}}, d_offset, 2'b00};

  assign w_is_branch = br_is_branch(d_branch_op);
  assign w_commit    = d_valid & ~d_stall & w_is_branch;

  assign d_taken       = d_valid & w_is_branch & br_cond(d_branch_op, w_rs_ext, w_rt_ext);
  assign d_redirect    = w_commit & (d_taken != d_pred_taken);
  assign d_redirect_pc = d_taken ? (d_pc + BR_SEQ_STEP + w_offset_ext)
                                 : (d_pc + BR_DELAY_STEP);

  sat_counter_table #(
    .ENTRIES (BHT_ENTRIES),
    .BITS    (CTR_BITS)
  ) u_bht (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (f_pc[IDX+1:2]),
    .o_rd_taken (f_pred_taken),
    .i_wr_en    (w_commit),
    .i_wr_idx   (d_pc[IDX+1:2]),
    .i_wr_up    (d_taken)
  );

  // Statistics stick at all-ones rather than wrapping back to a misleading small count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_commit) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (d_redirect && (r_mispredict_cnt != '1)) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign branch_cnt     = r_branch_cnt;
  assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed self-checking bench for branch_predict_resolve (default parameters).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_branch_predict_resolve;

  logic        clk;
  logic        reset;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic        d_valid;
  logic        d_stall;
  logic [2:0]  d_branch_op;
  logic [31:0] d_pc;
  logic        d_pred_taken;
  logic [31:0] d_rs;
  logic [31:0] d_rt;
  logic [15:0] d_offset;
  logic        d_taken;
  logic        d_redirect;
  logic [31:0] d_redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] expBr  = 0;
  logic [31:0] expMis = 0;

  branch_predict_resolve dut (
    .clk            (clk),
    .reset          (reset),
    .f_pc           (f_pc),
    .f_pred_taken   (f_pred_taken),
    .d_valid        (d_valid),
    .d_stall        (d_stall),
    .d_branch_op    (d_branch_op),
    .d_pc           (d_pc),
    .d_pred_taken   (d_pred_taken),
    .d_rs           (d_rs),
    .d_rt           (d_rt),
    .d_offset       (d_offset),
    .d_taken        (d_taken),
    .d_redirect     (d_redirect),
    .d_redirect_pc  (d_redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; d_valid = 1'b0; d_stall = 1'b0; d_branch_op = 3'd0;
    d_pc = 32'h0; d_pred_taken = 1'b0; d_rs = 32'h0; d_rt = 32'h0;
    d_offset = 16'h0; f_pc = 32'h3010;
    step(); step();
    #1;
    checks++; if (d_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken: got %b expected 0", d_taken); end
    checks++; if (d_redirect !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect: got %b expected 0", d_redirect); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_branch_cnt: got %0d expected 0", branch_cnt); end
    checks++; if (mispredict_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_mis_cnt: got %0d expected 0", mispredict_cnt); end
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred: got %b expected 0", f_pred_taken); end
    reset = 1'b0;
    step();
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_pred: got %b expected 0", f_pred_taken); end
  endtask

  task automatic test_signed_compare();
    // BGEZ on the most negative value, held stalled so nothing commits.
    d_valid = 1'b1; d_stall = 1'b1; d_branch_op = 3'd1; d_rs = 32'h8000_0000;
    d_pc = 32'h3000; d_offset = 16'h0004; d_pred_taken = 1'b0;
    #1;
    checks++; if (d_taken !== 1'b0) begin errors++; $display("[TB] FAIL bgez_neg_taken: got %b expected 0", d_taken); end
    d_stall = 1'b0; d_branch_op = 3'd2;
    #1;
    checks++; if (d_taken !== 1'b1) begin errors++; $display("[TB] FAIL bltz_neg_taken: got %b expected 1", d_taken); end
    checks++; if (d_redirect !== 1'b1) begin errors++; $display("[TB] FAIL bltz_redirect: got %b expected 1", d_redirect); end
    checks++; if (d_redirect_pc !== 32'h3014) begin errors++; $display("[TB] FAIL bltz_redirect_pc: got %h expected 00003014", d_redirect_pc); end
    step();
    d_valid = 1'b0;
    expBr = expBr + 1; expMis = expMis + 1;   // entry 0: 01 -> 10
    #1;
    checks++; if (mispredict_cnt !== expMis) begin errors++; $display("[TB] FAIL bltz_mis_cnt: got %0d expected %0d", mispredict_cnt, expMis); end
    checks++; if (branch_cnt !== expBr) begin errors++; $display("[TB] FAIL bltz_branch_cnt: got %0d expected %0d", branch_cnt, expBr); end
    checks++; if (d_taken !== 1'b0) begin errors++; $display("[TB] FAIL invalid_taken: got %b expected 0", d_taken); end
  endtask

  task automatic test_training();
    logic expPred [4];
    expPred[0] = 1'b1; expPred[1] = 1'b1; expPred[2] = 1'b1; expPred[3] = 1'b1;
    f_pc = 32'h3010; d_pc = 32'h3010; d_valid = 1'b1; d_stall = 1'b0;
    d_branch_op = 3'd6; d_rs = 32'd5; d_rt = 32'd5; d_pred_taken = 1'b0; d_offset = 16'h0;
    #1;
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL train_initial_pred: got %b expected 0", f_pred_taken); end
    for (int i = 0; i < 4; i++) begin
      step();
      expBr = expBr + 1; expMis = expMis + 1;
      checks++;
      if (f_pred_taken !== expPred[i]) begin
        errors++; $display("[TB] FAIL train_up_%0d: got %b expected %b", i, f_pred_taken, expPred[i]);
      end
    end
    // Counter at 11: first not-taken leaves 10, second leaves 01.
    d_rt = 32'd6; d_pred_taken = 1'b1;
    #1;
    checks++; if (d_redirect_pc !== 32'h3018) begin errors++; $display("[TB] FAIL train_nt_pc: got %h expected 00003018", d_redirect_pc); end
    step();
    expBr = expBr + 1; expMis = expMis + 1;
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL train_down_1: got %b expected 1", f_pred_taken); end
    step();
    expBr = expBr + 1; expMis = expMis + 1;
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL train_down_2: got %b expected 0", f_pred_taken); end
    d_valid = 1'b0;
    #1;
    checks++; if (branch_cnt !== expBr) begin errors++; $display("[TB] FAIL train_branch_cnt: got %0d expected %0d", branch_cnt, expBr); end
    checks++; if (mispredict_cnt !== expMis) begin errors++; $display("[TB] FAIL train_mis_cnt: got %0d expected %0d", mispredict_cnt, expMis); end
  endtask

  task automatic test_not_taken_redirect();
    d_valid = 1'b1; d_stall = 1'b0; d_branch_op = 3'd5; d_pc = 32'h3100;
    d_rs = 32'd7; d_rt = 32'd7; d_pred_taken = 1'b1; d_offset = 16'h0;
    #1;
    checks++; if (d_taken !== 1'b0) begin errors++; $display("[TB] FAIL bne_eq_taken: got %b expected 0", d_taken); end
    checks++; if (d_redirect !== 1'b1) begin errors++; $display("[TB] FAIL bne_eq_redirect: got %b expected 1", d_redirect); end
    checks++; if (d_redirect_pc !== 32'h3108) begin errors++; $display("[TB] FAIL bne_eq_pc: got %h expected 00003108", d_redirect_pc); end
    step();
    expBr = expBr + 1; expMis = expMis + 1;   // entry 0: 10 -> 01
    // Taken, correctly predicted, with a negative offset.
    d_rs = 32'd1; d_rt = 32'd2; d_offset = 16'hFFFF; d_pred_taken = 1'b1;
    #1;
    checks++; if (d_taken !== 1'b1) begin errors++; $display("[TB] FAIL bne_ne_taken: got %b expected 1", d_taken); end
    checks++; if (d_redirect !== 1'b0) begin errors++; $display("[TB] FAIL bne_ne_redirect: got %b expected 0", d_redirect); end
    checks++; if (d_redirect_pc !== 32'h3100) begin errors++; $display("[TB] FAIL neg_offset_pc: got %h expected 00003100", d_redirect_pc); end
    step();
    expBr = expBr + 1;                        // entry 0: 01 -> 10
    d_valid = 1'b0;
    #1;
    checks++; if (branch_cnt !== expBr) begin errors++; $display("[TB] FAIL nt_branch_cnt: got %0d expected %0d", branch_cnt, expBr); end
    checks++; if (mispredict_cnt !== expMis) begin errors++; $display("[TB] FAIL nt_mis_cnt: got %0d expected %0d", mispredict_cnt, expMis); end
  endtask

  task automatic test_stall();
    d_valid = 1'b1; d_stall = 1'b1; d_branch_op = 3'd3; d_pc = 32'h3200;
    d_rs = 32'd1; d_rt = 32'd0; d_pred_taken = 1'b0; d_offset = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (d_redirect !== 1'b0) begin errors++; $display("[TB] FAIL stall_redirect_%0d: got %b expected 0", i, d_redirect); end
      checks++; if (d_taken !== 1'b1) begin errors++; $display("[TB] FAIL stall_taken_%0d: got %b expected 1", i, d_taken); end
      checks++; if (branch_cnt !== expBr) begin errors++; $display("[TB] FAIL stall_branch_cnt_%0d: got %0d expected %0d", i, branch_cnt, expBr); end
      checks++; if (mispredict_cnt !== expMis) begin errors++; $display("[TB] FAIL stall_mis_cnt_%0d: got %0d expected %0d", i, mispredict_cnt, expMis); end
      step();
    end
    d_stall = 1'b0;
    #1;
    checks++; if (d_redirect !== 1'b1) begin errors++; $display("[TB] FAIL unstall_redirect: got %b expected 1", d_redirect); end
    checks++; if (d_redirect_pc !== 32'h3244) begin errors++; $display("[TB] FAIL unstall_pc: got %h expected 00003244", d_redirect_pc); end
    step();
    expBr = expBr + 1; expMis = expMis + 1;   // entry 0: 10 -> 11
    d_valid = 1'b0;
    #1;
    checks++; if (branch_cnt !== expBr) begin errors++; $display("[TB] FAIL unstall_branch_cnt: got %0d expected %0d", branch_cnt, expBr); end
    step();
    checks++; if (branch_cnt !== expBr) begin errors++; $display("[TB] FAIL stall_once_only: got %0d expected %0d", branch_cnt, expBr); end
    checks++; if (mispredict_cnt !== expMis) begin errors++; $display("[TB] FAIL unstall_mis_cnt: got %0d expected %0d", mispredict_cnt, expMis); end
  endtask

  task automatic test_back_to_back_alias();
    // f_pc 0x3040 and d_pc 0x3000 share entry 0, which sits at 11.
    f_pc = 32'h3040; d_pc = 32'h3000; d_valid = 1'b1; d_stall = 1'b0;
    d_branch_op = 3'd6; d_rs = 32'd1; d_rt = 32'd2; d_pred_taken = 1'b1; d_offset = 16'h0;
    #1;
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL alias_pre: got %b expected 1", f_pred_taken); end
    step();
    expBr = expBr + 1; expMis = expMis + 1;   // 11 -> 10
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL alias_same_cycle_old: got %b expected 1", f_pred_taken); end
    step();
    expBr = expBr + 1; expMis = expMis + 1;   // 10 -> 01
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL alias_next_cycle_new: got %b expected 0", f_pred_taken); end
    checks++; if (branch_cnt !== expBr) begin errors++; $display("[TB] FAIL b2b_branch_cnt: got %0d expected %0d", branch_cnt, expBr); end
    checks++; if (mispredict_cnt !== expMis) begin errors++; $display("[TB] FAIL b2b_mis_cnt: got %0d expected %0d", mispredict_cnt, expMis); end
  endtask

  task automatic test_reset_mid_run();
    // Taken commit at entry 0 (01 -> 10), then reset while another commit is active.
    d_rt = 32'd1; d_pred_taken = 1'b1;
    step();
    checks++; if (f_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL premid_pred: got %b expected 1", f_pred_taken); end
    reset = 1'b1;
    step();
    reset = 1'b0; d_valid = 1'b0;
    #1;
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pred: got %b expected 0", f_pred_taken); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("[TB] FAIL midreset_branch_cnt: got %0d expected 0", branch_cnt); end
    checks++; if (mispredict_cnt !== 32'd0) begin errors++; $display("[TB] FAIL midreset_mis_cnt: got %0d expected 0", mispredict_cnt); end
    f_pc = 32'h3010;
    step();
    checks++; if (f_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL midreset_entry4: got %b expected 0", f_pred_taken); end
    checks++; if (branch_cnt !== 32'd0) begin errors++; $display("[TB] FAIL midreset_hold_cnt: got %0d expected 0", branch_cnt); end
  endtask

  initial begin
    test_reset();
    test_signed_compare();
    test_training();
    test_not_taken_redirect();
    test_stall();
    test_back_to_back_alias();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch unit for the pipelined MIPS core: it predicts direction at Fetch from a table of saturating counters indexed by PC, and resolves direction at Decode with signed compares. On a misprediction it raises a one-cycle redirect with the correct PC. It trains the counters and keeps branch and mispredict statistics. It replaces the purely combinational P4 branch decision, which compared unsigned and had no memory.

## Interface
- `WIDTH`, default 32: operand width for the compared registers.
- `BHT_ENTRIES`, default 16: number of counter entries; must be a power of two and at least 2.
- `CTR_BITS`, default 2: width of each saturating counter; must be at least 1.
- Clocking: one clock `clk`. Reset `reset` is synchronous and active-high.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `f_pc`  in  32  fetch-stage PC used for the lookup.
- `f_pred_taken`  out  1  prediction for `f_pc`: counter MSB of entry `f_pc[IDX+1:2]`, where IDX = log2(BHT_ENTRIES).
- `d_valid`  in  1  a branch-capable instruction is in Decode.
- `d_stall`  in  1  Decode is stalled; no resolve or update is committed this cycle.
- `d_branch_op`  in  3  opcode from `br_pkg`.
- `d_pc`  in  32  PC of the Decode instruction.
- `d_pred_taken`  in  1  prediction that was carried down with the instruction.
- `d_rs`, `d_rt`  in  WIDTH  forwarded register operands.
- `d_offset`  in  16  branch immediate.
- `d_taken`  out  1  actual direction.
- `d_redirect`  out  1  misprediction; Fetch must redirect.
- `d_redirect_pc`  out  32  correct next PC when `d_redirect` is high.
- `branch_cnt`  out  32  count of committed conditional branches.
- `mispredict_cnt`  out  32  count of committed mispredictions.

## Operation
- Opcodes:
  - `BR_NONE`=0
  - `BR_BGEZ`=1
  - `BR_BLTZ`=2
  - `BR_BGTZ`=3
  - `BR_BLEZ`=4
  - `BR_BNE`=5
  - `BR_BEQ`=6
  - Values 7 are reserved and treated as NONE.
- All compares against zero are signed (two's complement at WIDTH). Examples: rs = 0x8000_0000 gives BLTZ taken and BGEZ not taken.
- BEQ and BNE compare the full WIDTH bits for equality.
- Define `commit` = d_valid & ~d_stall & (op ∈ 1..6).
- `d_taken` is combinational. It is 0 when `d_valid`=0 or the op is NONE/reserved, even while stalled.
- `d_redirect` is combinational and high when `commit` & (d_taken != d_pred_taken). It is held low while `d_stall`=1.
- `d_redirect_pc` is combinational:
  - When actually taken: d_pc + 4 + (sign-extended offset << 2).
  - When actually not taken: d_pc + 8 (delay slot already fetched).
  - Arithmetic is mod 2^32 and wraps silently.
- Counter training, on `commit` at the rising edge:
  - Entry `d_pc[IDX+1:2]` increments when taken, decrements when not taken.
  - Saturates at 2^CTR_BITS−1 and at 0.
- Lookup is a combinational read of the current table. There is no write-to-read bypass: on a same-cycle write and read of one entry, `f_pred_taken` shows the pre-edge value.
- Statistics:
  - `branch_cnt` increments on `commit`.
  - `mispredict_cnt` increments on `commit` & `d_redirect`.
  - Both saturate at 0xFFFF_FFFF; they do not wrap.
- Reset values:
  - Every counter resets to 2^(CTR_BITS−1)−1 (weakly not-taken; 01 for 2 bits).
  - `branch_cnt` and `mispredict_cnt` reset to 0.
  - Reset has priority over `commit` in the same cycle, so no update occurs.
  - With `d_valid`=0, every output is 0 during and after reset, except `f_pred_taken`=0 and `d_redirect_pc`, which is a don't-care.

## Timing
- Prediction: 0-cycle latency from `f_pc`.
- Resolution: 0-cycle latency, Decode-stage combinational.
- Counter update and statistics are visible on the cycle after the commit edge.
- A stall holds all state; the same instruction resolves once, on the cycle its stall drops.
- Back-to-back commits to the same entry accumulate, one step per cycle.

## Structure
- `br_pkg` holds:
  - `br_op_t` enum with the codes above;
  - the `BR_*` localparams;
  - the helper function `br_cond(op, rs, rt)` returning actual direction.
- Sub-module `sat_counter_table`, parametrised by entries and bits. It has 1 read port and 1 write port and contains the reset and saturation logic.
- The top level holds the compare, redirect and statistics logic.

## Test plan
- Signed compare: rs = 0x8000_0000 with op BLTZ, d_pred_taken=0, d_pc=0x3000 and offset=0x0004 gives d_taken=1, d_redirect=1 and d_redirect_pc=0x3014; mispredict_cnt becomes 1 on the next cycle.
- Training and saturation: four taken BEQ commits (rs=rt=5) at d_pc=0x3010 move the entry 01→10→11→11. `f_pc`=0x3010 then gives `f_pred_taken`=1; one not-taken commit leaves it 1, and two leave it 0.
- Not-taken redirect: BNE with rs=rt, d_pred_taken=1 and d_pc=0x3100 gives d_redirect=1 and d_redirect_pc=0x3108; a negative offset 0xFFFF on a taken path gives 0x3100.
- Stall: BGTZ with rs=1 held with d_stall=1 for 3 cycles keeps d_redirect=0 and both counts unchanged; releasing the stall gives exactly one commit and branch_cnt+1.
- Aliasing/no bypass: f_pc=0x3040 and d_pc=0x3000 (same index at 16 entries) in a commit cycle; f_pred_taken shows the old value and the new value appears on the next cycle.
- Reset mid-run: assert reset with a commit active. The counters return to 01, the statistics return to 0, and no update from that cycle survives.
